// File: rtl/time_glyph_streamer.sv
// BCD time-of-day counter that renders hh:mm:ss as a valid/ready pixel stream from an external glyph ROM.
// Build option HOUR12_EN: 12-hour display with blanked leading hour zero (counting stays 24-hour).
module time_glyph_streamer #(
  parameter int GLYPH_W = 13,
  parameter int GLYPH_H = 24,
  parameter int ADDR_W  = 9,
  parameter int PIX_W   = 24,
  parameter logic [PIX_W-1:0] FG_COLOR = 24'hFFFFFF,
  parameter logic [PIX_W-1:0] BG_COLOR = 24'h000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_time,
  input  logic [23:0]        init_time,
  input  logic               tick_1s,
  input  logic               frame_start,
  output logic [ADDR_W-1:0]  rom_addr,
  input  logic [GLYPH_W-1:0] rom_data,
  output logic [PIX_W-1:0]   pix_data,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               pix_last,
  output logic               busy,
  output logic               frame_done,
  output logic               pm_flag
);
  localparam int ROW_W = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
  localparam int COL_W = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(GLYPH_H - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(GLYPH_W - 1);
  localparam logic [3:0] CODE_COLON = 4'd10;
`ifdef HOUR12_EN
  localparam logic [3:0] CODE_BLANK = 4'd11;
`endif

  typedef enum logic [2:0] {IDLE, ADDR, WAIT, SHIFT, DONE} state_e;
  typedef logic [7:0][3:0] codes_t;

  function automatic logic bcd_valid(input logic [23:0] t);
    logic hours_ok;
    hours_ok = (t[23:20] <= 4'd1 && t[19:16] <= 4'd9) || (t[23:20] == 4'd2 && t[19:16] <= 4'd3);
    return hours_ok && (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  function automatic logic [23:0] bcd_tick(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    if (s0 != 4'd9) s0 = s0 + 4'd1;
    else begin
      s0 = 4'd0;
      if (s1 != 4'd5) s1 = s1 + 4'd1;
      else begin
        s1 = 4'd0;
        if (m0 != 4'd9) m0 = m0 + 4'd1;
        else begin
          m0 = 4'd0;
          if (m1 != 4'd5) m1 = m1 + 4'd1;
          else begin
            m1 = 4'd0;
            if (h1 == 4'd2 && h0 == 4'd3) begin
              h1 = 4'd0;
              h0 = 4'd0;
            end else if (h0 == 4'd9) begin
              h0 = 4'd0;
              h1 = h1 + 4'd1;
            end else h0 = h0 + 4'd1;
          end
        end
      end
    end
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  // Character 0 (hour tens) lands in the top nibble.
  function automatic codes_t glyph_codes(input logic [23:0] t);
    logic [3:0] d1, d0;
`ifdef HOUR12_EN
    logic [4:0] hr, hd;
    hr = 5'(t[23:20]) * 5'd10 + 5'(t[19:16]);
    if (hr == 5'd0)       hd = 5'd12;
    else if (hr > 5'd12)  hd = hr - 5'd12;
    else                  hd = hr;
    if (hd >= 5'd10) begin
      d1 = 4'd1;
      d0 = 4'(hd - 5'd10);
    end else begin
      d1 = CODE_BLANK;
      d0 = hd[3:0];
    end
`else
    d1 = t[23:20];
    d0 = t[19:16];
`endif
    return {d1, d0, CODE_COLON, t[15:12], t[11:8], CODE_COLON, t[7:4], t[3:0]};
  endfunction

  state_e             state_q, state_d;
  logic [23:0]        time_q, time_d;
  codes_t             snap_q, snap_d;
  logic [2:0]         char_q, char_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [COL_W-1:0]   col_q, col_d;
  logic [GLYPH_W-1:0] sh_q, sh_d;
  logic [ADDR_W-1:0]  rom_addr_q, addr_calc;
  logic [3:0]         cur_code;

  always_comb begin
    time_d = time_q;
    if (load_time)    time_d = bcd_valid(init_time) ? init_time : 24'h0;
    else if (tick_1s) time_d = bcd_tick(time_q);
  end

  assign cur_code  = snap_q[~char_q];
  assign addr_calc = ADDR_W'(cur_code) * ADDR_W'(GLYPH_H) + ADDR_W'(row_q);

  always_comb begin
    // NOTE: every next-state value gets a default first so no latch is inferred.
    state_d = state_q;
    snap_d  = snap_q;
    char_d  = char_q;
    row_d   = row_q;
    col_d   = col_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: if (frame_start) begin
        snap_d  = glyph_codes(time_q);
        char_d  = '0;
        row_d   = '0;
        col_d   = '0;
        state_d = ADDR;
      end
      ADDR: state_d = WAIT;
      WAIT: begin
        sh_d    = rom_data;
        col_d   = '0;
        state_d = SHIFT;
      end
      SHIFT: if (pix_ready) begin
        sh_d = {sh_q[GLYPH_W-2:0], 1'b0};
        if (col_q == COL_LAST) begin
          col_d   = '0;
          state_d = ADDR;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            if (char_q == 3'd7) state_d = DONE;
            else                char_d  = char_q + 3'd1;
          end else row_d = row_q + ROW_W'(1);
        end else col_d = col_q + COL_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q    <= IDLE;
      time_q     <= '0;
      snap_q     <= '0;
      char_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      sh_q       <= '0;
      rom_addr_q <= '0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      snap_q  <= snap_d;
      char_q  <= char_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sh_q    <= sh_d;
      if (state_q == ADDR) rom_addr_q <= addr_calc;
    end
  end

  assign rom_addr   = (state_q == ADDR) ? addr_calc : rom_addr_q;
  assign pix_valid  = (state_q == SHIFT);
  assign pix_data   = (pix_valid && sh_q[GLYPH_W-1]) ? FG_COLOR : BG_COLOR;
  assign pix_last   = pix_valid && (char_q == 3'd7) && (row_q == ROW_LAST) && (col_q == COL_LAST);
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);
  assign pm_flag    = (time_q[23:20] == 4'd2) || (time_q[23:20] == 4'd1 && time_q[19:16] >= 4'd2);
endmodule

// File: tb/tb_time_glyph_streamer.sv
// Self-checking bench for time_glyph_streamer: seconds-based time model, ROM model, expected pixel queue.
module tb_time_glyph_streamer;
  localparam int GW = 13;
  localparam int GH = 24;
  localparam int NPIX = 8 * GH * GW;
  localparam logic [23:0] FG = 24'hFFFFFF;
  localparam logic [23:0] BG = 24'h000000;

  logic        clk = 1'b0;
  logic        reset, load_time, tick_1s, frame_start, pix_ready;
  logic [23:0] init_time;
  logic [8:0]  rom_addr;
  logic [12:0] rom_data = '0;
  logic [23:0] pix_data;
  logic        pix_valid, pix_last, busy, frame_done, pm_flag;

  logic [12:0] rom_mem [512];
  int          exp_codes [8];
  int          model_sec;
  int          checks = 0;
  int          errors = 0;

  time_glyph_streamer dut (
    .clk(clk), .reset(reset), .load_time(load_time), .init_time(init_time),
    .tick_1s(tick_1s), .frame_start(frame_start), .rom_addr(rom_addr), .rom_data(rom_data),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_last(pix_last),
    .busy(busy), .frame_done(frame_done), .pm_flag(pm_flag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int load_val(input logic [23:0] v);
    int h1 = int'(v[23:20]);
    int h0 = int'(v[19:16]);
    int m1 = int'(v[15:12]);
    int m0 = int'(v[11:8]);
    int s1 = int'(v[7:4]);
    int s0 = int'(v[3:0]);
    if (h0 > 9 || h1 * 10 + h0 > 23 || m1 > 5 || m0 > 9 || s1 > 5 || s0 > 9) return 0;
    return (h1 * 10 + h0) * 3600 + (m1 * 10 + m0) * 60 + s1 * 10 + s0;
  endfunction

  function automatic void make_codes(input int sec);
    int h = sec / 3600;
    int m = (sec / 60) % 60;
    int s = sec % 60;
    int dh;
`ifdef HOUR12_EN
    dh = (h == 0) ? 12 : (h > 12) ? h - 12 : h;
    exp_codes[0] = (dh >= 10) ? 1 : 11;
    exp_codes[1] = dh % 10;
`else
    dh = h;
    exp_codes[0] = dh / 10;
    exp_codes[1] = dh % 10;
`endif
    exp_codes[2] = 10;
    exp_codes[3] = m / 10;
    exp_codes[4] = m % 10;
    exp_codes[5] = 10;
    exp_codes[6] = s / 10;
    exp_codes[7] = s % 10;
  endfunction

  task automatic do_load(input logic [23:0] v, input bit with_tick);
    load_time = 1'b1;
    init_time = v;
    tick_1s   = with_tick;
    @(negedge clk);
    load_time = 1'b0;
    tick_1s   = 1'b0;
    model_sec = load_val(v);
    check("pm_after_load", 32'(pm_flag), 32'(model_sec >= 43200));
  endtask

  task automatic pulse_tick();
    tick_1s = 1'b1;
    @(negedge clk);
    tick_1s = 1'b0;
    model_sec = (model_sec + 1) % 86400;
  endtask

  task automatic fill_rom(input bit fixed);
    for (int i = 0; i < 512; i++) rom_mem[i] = fixed ? 13'h1000 : 13'($urandom);
  endtask

  // Called at a negedge with the DUT idle. Optional mid-frame tick / ignored frame_start / reset.
  task automatic run_frame(input string tag, input int ready_pct, input int tick_at,
                           input int start_at, input int reset_at);
    logic [23:0] exp_pix[$];
    int          exp_addr[$];
    int idx, rows, cyc, first_cyc, last_cyc;
    int pix_err, addr_err, hold_err, early_done, stray;
    bit prev_valid, prev_stall, rdy;
    logic [23:0] prev_data;
    logic        prev_last;
    make_codes(model_sec);
    for (int c = 0; c < 8; c++)
      for (int r = 0; r < GH; r++) begin
        int a = exp_codes[c] * GH + r;
        logic [12:0] word = rom_mem[a];
        exp_addr.push_back(a);
        for (int w = 0; w < GW; w++) exp_pix.push_back(word[GW-1-w] ? FG : BG);
      end
    idx = 0; rows = 0; first_cyc = -1; last_cyc = -1;
    pix_err = 0; addr_err = 0; hold_err = 0; early_done = 0;
    prev_valid = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check({tag, "_busy_start"}, 32'(busy), 32'd1);
    check({tag, "_first_addr"}, 32'(rom_addr), 32'(exp_addr[0]));
    cyc = 1;
    while (idx < NPIX && cyc < 40000) begin
      if (pix_valid && !prev_valid) begin
        if (rows >= exp_addr.size() || 32'(rom_addr) != 32'(exp_addr[rows])) addr_err++;
        if (rows == 0) first_cyc = cyc;
        rows++;
      end
      if (prev_stall && (pix_data !== prev_data || pix_last !== prev_last)) hold_err++;
      if (frame_done) early_done++;
      if (reset_at != 0 && cyc == reset_at) begin
        reset = 1'b1; pix_ready = 1'b1; tick_1s = 1'b0; frame_start = 1'b0;
        @(negedge clk);
        check({tag, "_rst_valid"}, 32'(pix_valid), 32'd0);
        check({tag, "_rst_busy"}, 32'(busy), 32'd0);
        check({tag, "_rst_done"}, 32'(frame_done), 32'd0);
        check({tag, "_rst_addr"}, 32'(rom_addr), 32'd0);
        check({tag, "_rst_data"}, 32'(pix_data), 32'(BG));
        reset = 1'b0;
        model_sec = 0;
        stray = 0;
        repeat (20) begin
          @(negedge clk);
          if (frame_done || busy || pix_valid) stray++;
        end
        check({tag, "_rst_quiet"}, 32'(stray), 32'd0);
        check({tag, "_rst_pm"}, 32'(pm_flag), 32'd0);
        return;
      end
      rdy = ($urandom_range(99) < ready_pct);
      pix_ready = rdy;
      tick_1s = (cyc == tick_at);
      if (tick_1s) model_sec = (model_sec + 1) % 86400;
      frame_start = (cyc == start_at);
      if (pix_valid && rdy) begin
        if (pix_data !== exp_pix[idx] || pix_last !== (idx == NPIX - 1)) pix_err++;
        idx++;
        last_cyc = cyc;
      end
      prev_valid = pix_valid;
      prev_stall = pix_valid && !rdy;
      prev_data  = pix_data;
      prev_last  = pix_last;
      @(negedge clk);
      cyc++;
    end
    tick_1s = 1'b0;
    frame_start = 1'b0;
    check({tag, "_handshakes"}, 32'(idx), 32'(NPIX));
    check({tag, "_pixels"}, 32'(pix_err), 32'd0);
    check({tag, "_row_addrs"}, 32'(addr_err), 32'd0);
    check({tag, "_rows"}, 32'(rows), 32'(8 * GH));
    check({tag, "_stall_hold"}, 32'(hold_err), 32'd0);
    check({tag, "_early_done"}, 32'(early_done), 32'd0);
    check({tag, "_latency"}, 32'(first_cyc), 32'd3);
    if (ready_pct >= 100) check({tag, "_last_cycle"}, 32'(last_cyc), 32'(3 + 8 * GH * (GW + 2) - 3));
    check({tag, "_done_pulse"}, 32'(frame_done), 32'd1);
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    check({tag, "_valid_in_done"}, 32'(pix_valid), 32'd0);
    pix_ready = 1'b1;
    @(negedge clk);
    check({tag, "_done_cleared"}, 32'(frame_done), 32'd0);
    check({tag, "_busy_cleared"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b1; load_time = 1'b0; tick_1s = 1'b0; frame_start = 1'b0;
    pix_ready = 1'b0; init_time = '0; model_sec = 0;
    fill_rom(1'b0);
    repeat (3) @(negedge clk);
    check("reset_addr", 32'(rom_addr), 32'd0);
    check("reset_valid", 32'(pix_valid), 32'd0);
    check("reset_last", 32'(pix_last), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(frame_done), 32'd0);
    check("reset_data", 32'(pix_data), 32'(BG));
    check("reset_pm", 32'(pm_flag), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    do_load(24'h235958, 1'b0);
    pulse_tick();
    pulse_tick();
    check("pm_after_wrap", 32'(pm_flag), 32'(model_sec >= 43200));
    run_frame("f1_wrap", 100, 0, 0, 0);

    do_load(24'h123456, 1'b0);
    run_frame("f2_123456", 100, 0, 0, 0);

    fill_rom(1'b1);
    run_frame("f3_stall", 60, 50, 300, 0);

    fill_rom(1'b0);
    repeat ($urandom_range(150, 50)) pulse_tick();
    check("pm_after_ticks", 32'(pm_flag), 32'(model_sec >= 43200));
    run_frame("f4_next", 70, 0, 0, 0);

    do_load(24'h000500, 1'b1);
    run_frame("f5_load_tick", 85, 0, 0, 0);

    do_load(24'h130000, 1'b0);
    run_frame("f6_pm", 75, 0, 0, 0);

    do_load(24'h256099, 1'b1);
    run_frame("f7_invalid", 80, 0, 0, 0);

    do_load(24'h214530, 1'b0);
    run_frame("f8_reset", 90, 0, 0, 500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
